mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single data memory (mem_data) between the core's load/store path (port 0) and a host/debug loader (port 1).
- Sits between the requesters and the mem_data instance.
- Sequences each access through a small FSM with round-robin priority, range checking and a registered read response.

---
 rtl/mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port data memory (mem_data) between the core load/store
// path (port 0) and the host/debug loader (port 1).
//
// The arbiter takes one request at a time through IDLE -> ACCESS (-> RESP).
// - Contention is resolved round-robin. Port 0 wins the first contention after reset.
// - Out-of-range accesses raise err. An out-of-range write is suppressed.
//   An out-of-range read returns 0.
// - Read data is registered before it is returned.
//
// Optional feature: define MEM_ARB_PERF_EN to add per-port 16-bit saturating
// grant counters (p0_count, p1_count) with a synchronous clear (perf_clr).
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int p_WORD_LEN      = 16,
   parameter int p_ADDR_LEN      = 16,
   parameter int p_DATA_MEM_SIZE = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   // port 0: core load/store path
   input  logic                  p0_req,
   input  logic                  p0_wen,
   input  logic [p_ADDR_LEN-1:0] p0_addr,
   input  logic [p_WORD_LEN-1:0] p0_wdata,
   output logic                  p0_gnt,
   output logic                  p0_rvalid,
   output logic [p_WORD_LEN-1:0] p0_rdata,
   // port 1: host/debug loader
   input  logic                  p1_req,
   input  logic                  p1_wen,
   input  logic [p_ADDR_LEN-1:0] p1_addr,
   input  logic [p_WORD_LEN-1:0] p1_wdata,
   output logic                  p1_gnt,
   output logic                  p1_rvalid,
   output logic [p_WORD_LEN-1:0] p1_rdata,
   // mem_data interface
   output logic [p_ADDR_LEN-1:0] mem_addr,
   output logic [p_WORD_LEN-1:0] mem_wdata,
   output logic                  mem_wen,
   input  logic [p_WORD_LEN-1:0] mem_rdata,
`ifdef MEM_ARB_PERF_EN
   input  logic                  perf_clr,
   output logic [15:0]           p0_count,
   output logic [15:0]           p1_count,
`endif
   output logic                  busy,
   output logic                  err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_e;

   localparam logic [31:0] lp_MEM_SIZE = 32'(p_DATA_MEM_SIZE);

   state_e                  state_q,   state_d;
   logic                    rr_last_q, rr_last_d;   // port granted most recently
   logic                    win_q,     win_d;       // port owning the current access
   logic                    wen_q,     wen_d;
   logic [p_ADDR_LEN-1:0]   addr_q,    addr_d;
   logic [p_WORD_LEN-1:0]   wdata_q,   wdata_d;
   logic [p_WORD_LEN-1:0]   rdata_q,   rdata_d;     // registered read response
   logic [p_WORD_LEN-1:0]   p0_hold_q, p0_hold_d;   // last data returned to port 0
   logic [p_WORD_LEN-1:0]   p1_hold_q, p1_hold_d;   // last data returned to port 1
   logic                    in_range;
   logic                    winner;

   // Unsigned full-width compare; addresses never wrap into the valid range.
   assign in_range = (32'(addr_q) < lp_MEM_SIZE);
   assign busy     = (state_q != ST_IDLE);

   // Next-state, arbitration and output decode.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one
      // unassigned; that is what keeps this block free of inferred latches.
      state_d   = state_q;
      rr_last_d = rr_last_q;
      win_d     = win_q;
      wen_d     = wen_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      p0_hold_d = p0_hold_q;
      p1_hold_d = p1_hold_q;
      p0_gnt    = 1'b0;
      p1_gnt    = 1'b0;
      p0_rvalid = 1'b0;
      p1_rvalid = 1'b0;
      p0_rdata  = p0_hold_q;
      p1_rdata  = p1_hold_q;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wen   = 1'b0;
      err       = 1'b0;

      // Single requester wins outright; on contention the port not served last wins.
      winner = (p0_req && p1_req) ? ~rr_last_q : p1_req;

      unique case (state_q)
         ST_IDLE: begin
            // Grants are combinational from req, so they are gated by reset
            // to keep every output low while reset is asserted.
            if ((p0_req || p1_req) && rst) begin
               p0_gnt    = ~winner;
               p1_gnt    = winner;
               win_d     = winner;
               rr_last_d = winner;
               wen_d     = winner ? p1_wen   : p0_wen;
               addr_d    = winner ? p1_addr  : p0_addr;
               wdata_d   = winner ? p1_wdata : p0_wdata;
               state_d   = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_wen   = wen_q & in_range;
            err       = ~in_range;
            if (wen_q) begin
               state_d = ST_IDLE;
            end else begin
               rdata_d = in_range ? mem_rdata : '0;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (win_q) begin
               p1_rvalid = 1'b1;
               p1_rdata  = rdata_q;
               p1_hold_d = rdata_q;
            end else begin
               p0_rvalid = 1'b1;
               p0_rdata  = rdata_q;
               p0_hold_d = rdata_q;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; async reset clears everything so the
   // decoded memory strobes drop as soon as rst falls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         rr_last_q <= 1'b1;
         win_q     <= 1'b0;
         wen_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         p0_hold_q <= '0;
         p1_hold_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         win_q     <= win_d;
         wen_q     <= wen_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         p0_hold_q <= p0_hold_d;
         p1_hold_q <= p1_hold_d;
      end
   end

`ifdef MEM_ARB_PERF_EN
   logic [15:0] p0_count_q, p0_count_d;
   logic [15:0] p1_count_q, p1_count_d;

   // Saturating grant counters; clear beats increment in the same cycle.
   always_comb begin
      p0_count_d = p0_count_q;
      p1_count_d = p1_count_q;
      if (perf_clr) begin
         p0_count_d = '0;
         p1_count_d = '0;
      end else begin
         if (p0_gnt && (p0_count_q != 16'hFFFF)) p0_count_d = p0_count_q + 16'd1;
         if (p1_gnt && (p1_count_q != 16'hFFFF)) p1_count_d = p1_count_q + 16'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p0_count_q <= '0;
         p1_count_q <= '0;
      end else begin
         p0_count_q <= p0_count_d;
         p1_count_q <= p1_count_d;
      end
   end

   assign p0_count = p0_count_q;
   assign p1_count = p1_count_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Bench for mem_arbiter. It includes a behavioural mem_data model with a
// combinational read and a write on the clock edge. Out-of-range reads
// return a junk pattern, so the arbiter must mask them itself.
// The bench runs a table of single transactions, then hand-written
// multi-cycle sequences, then a randomized run checked against a
// transaction-level model.
// Define MEM_ARB_PERF_EN to also exercise the grant counters.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req     [2];
   logic        wen_i   [2];
   logic [15:0] addr_i  [2];
   logic [15:0] wdata_i [2];
   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wen, busy, err;
   logic [15:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
   logic        perf_clr = 1'b0;
   logic [15:0] p0_count, p1_count;
`endif

   logic [15:0] mem  [1024] = '{default: '0};
   logic [15:0] mmem [1024];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .p0_req(req[0]), .p0_wen(wen_i[0]), .p0_addr(addr_i[0]), .p0_wdata(wdata_i[0]),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(req[1]), .p1_wen(wen_i[1]), .p1_addr(addr_i[1]), .p1_wdata(wdata_i[1]),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata),
`ifdef MEM_ARB_PERF_EN
      .perf_clr(perf_clr), .p0_count(p0_count), .p1_count(p1_count),
`endif
      .busy(busy), .err(err)
   );

   // mem_data model
   assign mem_rdata = (mem_addr < 16'd1024) ? mem[mem_addr[9:0]] : 16'hDEAD;
   always @(posedge clk) if (mem_wen && mem_addr < 16'd1024) mem[mem_addr[9:0]] <= mem_wdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic gnt_of(input int p);
      return (p != 0) ? p1_gnt : p0_gnt;
   endfunction
   function automatic logic rv_of(input int p);
      return (p != 0) ? p1_rvalid : p0_rvalid;
   endfunction
   function automatic logic [15:0] rd_of(input int p);
      return (p != 0) ? p1_rdata : p0_rdata;
   endfunction

   task automatic wait_gnt(input int p, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt_of(p)) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_any(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (p0_gnt || p1_gnt) begin ok = 1'b1; break; end
      end
   endtask

   task automatic drop_all();
      req[0] = 1'b0;
      req[1] = 1'b0;
   endtask

   typedef struct {
      int          port;
      bit          wen;
      logic [15:0] addr;
      logic [15:0] wdata;
      bit          exp_err;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   // One isolated transaction: gnt, then ACCESS checks, then RESP (reads) or
   // a check that mem_wen lasts exactly one cycle (writes).
   task automatic run_vec(input int idx, input vec_t v);
      bit ok;
      @(posedge clk); #1;
      req[v.port] = 1'b1; wen_i[v.port] = v.wen; addr_i[v.port] = v.addr; wdata_i[v.port] = v.wdata;
      wait_gnt(v.port, ok);
      check($sformatf("v%0d_gnt", idx), 32'(ok), 1);
      @(posedge clk); #1;
      req[v.port] = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
      check($sformatf("v%0d_mem_wen", idx), 32'(mem_wen), 32'(v.wen && !v.exp_err));
      if (v.wen && !v.exp_err) begin
         check($sformatf("v%0d_mem_addr", idx), 32'(mem_addr), 32'(v.addr));
         check($sformatf("v%0d_mem_wdata", idx), 32'(mem_wdata), 32'(v.wdata));
      end
      @(negedge clk);
      if (v.wen) begin
         check($sformatf("v%0d_wen_off", idx), 32'(mem_wen), 0);
      end else begin
         check($sformatf("v%0d_rvalid", idx), 32'(rv_of(v.port)), 1);
         check($sformatf("v%0d_rvalid_other", idx), 32'(rv_of(1 - v.port)), 0);
         check($sformatf("v%0d_rdata", idx), 32'(rd_of(v.port)), 32'(v.exp_rdata));
      end
   endtask

   function automatic logic [15:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      return 16'($urandom_range(0, 15));
      else if (r < 9) return 16'($urandom_range(1020, 1027));
      else            return 16'($urandom);
   endfunction

   initial begin
      bit ok;
      for (int p = 0; p < 2; p++) begin
         req[p] = 1'b0; wen_i[p] = 1'b0; addr_i[p] = '0; wdata_i[p] = '0;
      end

      vecs[0] = '{0, 1'b1, 16'd5,     16'hBEEF, 1'b0, 16'h0000};
      vecs[1] = '{0, 1'b0, 16'd5,     16'h0000, 1'b0, 16'hBEEF};
      vecs[2] = '{1, 1'b1, 16'd1024,  16'h1234, 1'b1, 16'h0000};
      vecs[3] = '{1, 1'b0, 16'd1024,  16'h0000, 1'b1, 16'h0000};
      vecs[4] = '{1, 1'b1, 16'd1023,  16'hA5A5, 1'b0, 16'h0000};
      vecs[5] = '{0, 1'b0, 16'd1023,  16'h0000, 1'b0, 16'hA5A5};
      vecs[6] = '{1, 1'b0, 16'd5,     16'h0000, 1'b0, 16'hBEEF};
      vecs[7] = '{0, 1'b1, 16'hFFFF,  16'h5555, 1'b1, 16'h0000};
      vecs[8] = '{0, 1'b0, 16'd0,     16'h0000, 1'b0, 16'h0000};

      // ---------------- reset state ----------------
      #12;
      check("rst_busy", 32'(busy), 0);
      check("rst_gnt", 32'({p0_gnt, p1_gnt}), 0);
      check("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 0);
      check("rst_mem", 32'({mem_wen, mem_addr, mem_wdata}), 0);
      check("rst_rdata", 32'({p0_rdata, p1_rdata}), 0);
      check("rst_err", 32'(err), 0);
      @(negedge clk); rst = 1'b1;

      // ---------------- table of single transactions ----------------
      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
      check("oor_write_kept_out", 32'(mem[0]), 0);

      // ---------------- contention from reset: grants 0,1,0,1 ----------------
      @(posedge clk); #1;
      rst = 1'b0;
      req[0] = 1'b1; wen_i[0] = 1'b0; addr_i[0] = 16'd5;
      req[1] = 1'b1; wen_i[1] = 1'b0; addr_i[1] = 16'd1023;
      @(negedge clk);
      check("rst_gnt_gated", 32'({p0_gnt, p1_gnt}), 0);
      @(posedge clk); #1 rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         int ep;
         ep = k % 2;
         wait_any(ok);
         check($sformatf("rr%0d_seen", k), 32'(ok), 1);
         check($sformatf("rr%0d_gnt", k), 32'({p1_gnt, p0_gnt}), (ep != 0) ? 2 : 1);
         @(negedge clk);
         @(negedge clk);
         check($sformatf("rr%0d_rvalid", k), 32'({p1_rvalid, p0_rvalid}), (ep != 0) ? 2 : 1);
         check($sformatf("rr%0d_rdata", k), 32'(rd_of(ep)), (ep != 0) ? 32'h A5A5 : 32'h BEEF);
      end
      drop_all();
      repeat (4) @(posedge clk);

      // ---------------- reset during ACCESS (read, then write) ----------------
      for (int w = 0; w < 2; w++) begin
         @(posedge clk); #1;
         req[0] = 1'b1; wen_i[0] = (w != 0); addr_i[0] = 16'd7; wdata_i[0] = 16'h1234;
         wait_gnt(0, ok);
         check($sformatf("ra%0d_gnt", w), 32'(ok), 1);
         @(posedge clk); #2;
         req[0] = 1'b0;
         rst = 1'b0;
         #1;
         check($sformatf("ra%0d_busy", w), 32'(busy), 0);
         check($sformatf("ra%0d_mem", w), 32'({mem_wen, mem_addr, mem_wdata}), 0);
         check($sformatf("ra%0d_err", w), 32'(err), 0);
         repeat (2) begin
            @(negedge clk);
            check($sformatf("ra%0d_no_rvalid", w), 32'(p0_rvalid), 0);
         end
         @(posedge clk); #1 rst = 1'b1;
         repeat (2) begin
            @(negedge clk);
            check($sformatf("ra%0d_no_rvalid_after", w), 32'(p0_rvalid), 0);
         end
         check($sformatf("ra%0d_write_aborted", w), 32'(mem[7]), 0);
         @(posedge clk); #1;
         req[0] = 1'b1; wen_i[0] = 1'b0; addr_i[0] = 16'd5;
         req[1] = 1'b1; wen_i[1] = 1'b0; addr_i[1] = 16'd5;
         wait_any(ok);
         check($sformatf("ra%0d_first_gnt", w), 32'({p1_gnt, p0_gnt}), 1);
         @(posedge clk); #1 drop_all();
         repeat (3) @(posedge clk);
      end

      // ---------------- p1_req rises during port 0 RESP ----------------
      @(posedge clk); #1;
      req[0] = 1'b1; wen_i[0] = 1'b0; addr_i[0] = 16'd5;
      wait_gnt(0, ok);
      check("late_p0_gnt", 32'(ok), 1);
      @(posedge clk); #1 req[0] = 1'b0;
      @(posedge clk); #1;
      req[1] = 1'b1; wen_i[1] = 1'b0; addr_i[1] = 16'd1023;
      @(negedge clk);
      check("late_resp_rvalid", 32'(p0_rvalid), 1);
      check("late_no_gnt_in_resp", 32'(p1_gnt), 0);
      check("late_busy_in_resp", 32'(busy), 1);
      @(negedge clk);
      check("late_p1_gnt_idle", 32'(p1_gnt), 1);
      @(posedge clk); #1 req[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("late_p1_rvalid", 32'(p1_rvalid), 1);
      check("late_p1_rdata", 32'(p1_rdata), 32'h A5A5);
      check("late_p0_rdata_held", 32'(p0_rdata), 32'h BEEF);

      // ---------------- randomized run vs. transaction-level model ----------------
      @(posedge clk); #1 rst = 1'b0;
      #2 rst = 1'b1;
      mmem = mem;
      begin
         int          next_free, g, t_port, last_w;
         bit          have, t_wen, t_oor;
         logic [15:0] t_data, t_addr;
         logic [15:0] last_rd [2];
         bit          granted [2];
         next_free = 0; g = -10; t_port = 0; last_w = 1; have = 1'b0;
         t_wen = 1'b0; t_oor = 1'b0; t_data = '0; t_addr = '0;
         last_rd[0] = '0; last_rd[1] = '0;
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            req[p] = ($urandom_range(0, 2) != 0); wen_i[p] = 1'($urandom_range(0, 1));
            addr_i[p] = pick_addr(); wdata_i[p] = 16'($urandom);
         end
         for (int c = 0; c < 3000; c++) begin
            int  w;
            bit  exp_wen, exp_err;
            bit  exp_rv [2];
            @(negedge clk);
            granted[0] = 1'b0; granted[1] = 1'b0; w = -1;
            if (c >= next_free && (req[0] || req[1])) begin
               w = (req[0] && req[1]) ? 1 - last_w : (req[1] ? 1 : 0);
               granted[w] = 1'b1;
            end
            exp_wen = 1'b0; exp_err = 1'b0; exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
            if (have && c == g + 1) begin
               exp_err = t_oor;
               exp_wen = t_wen && !t_oor;
            end
            if (have && !t_wen && c == g + 2) begin
               exp_rv[t_port] = 1'b1;
               last_rd[t_port] = t_data;
            end
            check("rnd_gnt0", 32'(p0_gnt), 32'(granted[0]));
            check("rnd_gnt1", 32'(p1_gnt), 32'(granted[1]));
            check("rnd_busy", 32'(busy), 32'(have && c > g && c < next_free));
            check("rnd_err", 32'(err), 32'(exp_err));
            check("rnd_mem_wen", 32'(mem_wen), 32'(exp_wen));
            if (exp_wen) check("rnd_mem_addr", 32'(mem_addr), 32'(t_addr));
            check("rnd_rvalid0", 32'(p0_rvalid), 32'(exp_rv[0]));
            check("rnd_rvalid1", 32'(p1_rvalid), 32'(exp_rv[1]));
            check("rnd_rdata0", 32'(p0_rdata), 32'(last_rd[0]));
            check("rnd_rdata1", 32'(p1_rdata), 32'(last_rd[1]));
            if (w >= 0) begin
               have = 1'b1; g = c; t_port = w; last_w = w;
               t_wen = wen_i[w]; t_addr = addr_i[w];
               t_oor = (addr_i[w] >= 16'd1024);
               t_data = t_oor ? 16'h0000 : mmem[addr_i[w][9:0]];
               if (t_wen && !t_oor) mmem[addr_i[w][9:0]] = wdata_i[w];
               next_free = c + (t_wen ? 2 : 3);
            end
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
               if (granted[p] || !req[p]) begin
                  req[p] = ($urandom_range(0, 2) != 0); wen_i[p] = 1'($urandom_range(0, 1));
                  addr_i[p] = pick_addr(); wdata_i[p] = 16'($urandom);
               end
            end
         end
         drop_all();
         repeat (4) @(posedge clk);
      end

`ifdef MEM_ARB_PERF_EN
      // ---------------- grant counters ----------------
      begin
         int n;
         @(posedge clk); #1 rst = 1'b0;
         #2 rst = 1'b1;
         @(negedge clk);
         check("perf_rst", 32'({p0_count, p1_count}), 0);
         @(posedge clk); #1;
         req[1] = 1'b1; wen_i[1] = 1'b1; addr_i[1] = 16'd9; wdata_i[1] = 16'h0001;
         wait_gnt(1, ok);
         check("perf_p1_gnt", 32'(ok), 1);
         @(posedge clk); #1 req[1] = 1'b0;
         req[0] = 1'b1; wen_i[0] = 1'b1; addr_i[0] = 16'd9; wdata_i[0] = 16'h0002;
         n = 0;
         for (int c = 0; c < 150000 && n < 70000; c++) begin
            @(negedge clk);
            if (p0_gnt) n++;
         end
         check("perf_p0_grants", 32'(n), 70000);
         @(posedge clk); #1 req[0] = 1'b0;
         repeat (3) @(posedge clk);
         @(negedge clk);
         check("perf_p0_sat", 32'(p0_count), 32'h FFFF);
         check("perf_p1_one", 32'(p1_count), 1);
         @(posedge clk); #1 perf_clr = 1'b1;
         @(posedge clk); #1 perf_clr = 1'b0;
         @(negedge clk);
         check("perf_clr", 32'({p0_count, p1_count}), 0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
